// File: rtl/alu_sequencer.sv
// Single-issue sequencer for the 8-bit ALU and the LOAD/STORE memory path.
// Holds a small register file; one instruction in flight, completion reported on done/err/result.
package alu_seq_pkg;
    typedef logic [2:0] opcode_t;
    localparam opcode_t OP_ADD   = 3'd0;
    localparam opcode_t OP_AND   = 3'd1;
    localparam opcode_t OP_XOR   = 3'd2;
    localparam opcode_t OP_LOAD  = 3'd3;
    localparam opcode_t OP_STORE = 3'd4;
endpackage

module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS   = 4,
    parameter int IDX_W   = $clog2(NREGS),
    parameter int TIMEOUT = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  opcode_t          instr_op,
    input  logic [IDX_W-1:0] instr_rd,
    input  logic [IDX_W-1:0] instr_rs1,
    input  logic [IDX_W-1:0] instr_rs2,
    input  logic             reg_wr_en,
    input  logic [IDX_W-1:0] reg_wr_idx,
    input  logic [7:0]       reg_wr_data,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output opcode_t          alu_op,
    input  logic [7:0]       alu_result,
    output logic             mem_req,
    output logic             mem_we,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       result
);
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   rf [NREGS];
    opcode_t             op_q;
    opcode_t             alu_op_q;
    logic [IDX_W-1:0]    rd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [DATA_W-1:0]   mem_addr_q, mem_wdata_q;
    logic [DATA_W-1:0]   result_q;
    logic                err_q;
    logic                accept, op_alu, op_mem, timeout_hit;

    // Operand read at accept, forwarding a same-cycle external write.
    function automatic logic [DATA_W-1:0] rd_fwd(input logic [IDX_W-1:0] idx);
        return (reg_wr_en && reg_wr_idx == idx) ? reg_wr_data : rf[idx];
    endfunction

    assign accept      = instr_valid && (state == S_IDLE);
    assign op_alu      = (instr_op == OP_ADD) || (instr_op == OP_AND) || (instr_op == OP_XOR);
    assign op_mem      = (instr_op == OP_LOAD) || (instr_op == OP_STORE);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = op_alu ? S_EXEC : (op_mem ? S_MEM : S_DONE);
            S_EXEC: state_nxt = S_DONE;
            S_MEM:  if (mem_ack || timeout_hit) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        busy        = (state != S_IDLE);
        mem_req     = (state == S_MEM);
        mem_we      = (state == S_MEM) && (op_q == OP_STORE);
        done        = (state == S_DONE);
        err         = (state == S_DONE) && err_q;
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign result    = result_q;

    // FSM writeback is assigned after the external write so it wins on an index clash.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            op_q        <= OP_ADD;
            alu_op_q    <= OP_ADD;
            rd_q        <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            if (reg_wr_en) rf[reg_wr_idx] <= reg_wr_data;
            case (state)
                S_IDLE: if (accept) begin
                    op_q  <= instr_op;
                    rd_q  <= instr_rd;
                    cnt_q <= '0;
                    err_q <= !(op_alu || op_mem);
                    if (op_alu) begin
                        alu_a_q  <= rd_fwd(instr_rs1);
                        alu_b_q  <= rd_fwd(instr_rs2);
                        alu_op_q <= instr_op;
                    end
                    if (op_mem) begin
                        mem_addr_q  <= rd_fwd(instr_rs1);
                        mem_wdata_q <= rd_fwd(instr_rs2);
                    end
                end
                S_EXEC: begin
                    rf[rd_q] <= alu_result;
                    result_q <= alu_result;
                    err_q    <= 1'b0;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op_q == OP_LOAD) begin
                            rf[rd_q] <= mem_rdata;
                            result_q <= mem_rdata;
                        end else begin
                            result_q <= mem_wdata_q;
                        end
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: vector table, directed multi-cycle sequences and
// randomized instructions checked against a register-file/latency model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int NREGS   = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 16;

    logic             aclk, aresetn;
    logic             instr_valid, instr_ready;
    opcode_t          instr_op;
    logic [IDX_W-1:0] instr_rd, instr_rs1, instr_rs2;
    logic             reg_wr_en;
    logic [IDX_W-1:0] reg_wr_idx;
    logic [7:0]       reg_wr_data;
    logic [7:0]       alu_a, alu_b, alu_result;
    opcode_t          alu_op;
    logic             mem_req, mem_we, mem_ack;
    logic [7:0]       mem_addr, mem_wdata, mem_rdata;
    logic             busy, done, err;
    logic [7:0]       result;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_regs [NREGS];
    logic [7:0] m_result;

    alu_sequencer #(.NREGS(NREGS), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Combinational ALU attached to the sequencer.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            default: alu_result = 8'hEE;
        endcase
    end

    function automatic logic [7:0] alu_ref(input opcode_t op, input logic [7:0] a, input logic [7:0] b);
        int s;
        case (op)
            OP_ADD:  s = (int'(a) + int'(b)) % 256;
            OP_AND:  s = int'(a & b);
            default: s = int'(a ^ b);
        endcase
        return 8'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_rf(input string name);
        for (int i = 0; i < NREGS; i++) chk(name, 32'(dut.rf[i]), 32'(m_regs[i]));
    endtask

    task automatic set_reg(input logic [IDX_W-1:0] idx, input logic [7:0] d);
        reg_wr_en = 1'b1; reg_wr_idx = idx; reg_wr_data = d;
        @(posedge aclk); #1;
        reg_wr_en = 1'b0;
        m_regs[idx] = d;
    endtask

    // Issue one instruction, respond on the memory side, and check timing and results.
    // ack_k: MEM cycle carrying the ack (0 = never). ext_n: cycle of an external
    // register write relative to the accept cycle (0), -1 = none.
    task automatic run_instr(input opcode_t op, input logic [IDX_W-1:0] rd,
                             input logic [IDX_W-1:0] rs1, input logic [IDX_W-1:0] rs2,
                             input int ack_k, input logic [7:0] rdata,
                             input int ext_n, input logic [IDX_W-1:0] ext_idx,
                             input logic [7:0] ext_data);
        logic [7:0] a, b, wb_val;
        int exp_done, done_n, req_cnt, w, n;
        bit is_alu, is_mem, wb, exp_err, addr_ok, ext_early, ext_late;
        if (ext_n == 0) m_regs[ext_idx] = ext_data;
        a = m_regs[rs1];
        b = m_regs[rs2];
        is_alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        wb = 0; w = 0; exp_err = 0; wb_val = 8'h00; exp_done = 1;
        if (is_alu) begin
            exp_done = 2; wb = 1; w = 1; wb_val = alu_ref(op, a, b); m_result = wb_val;
        end else if (is_mem) begin
            if (ack_k >= 1 && ack_k <= TIMEOUT) begin
                exp_done = ack_k + 1;
                if (op == OP_LOAD) begin wb = 1; w = ack_k; wb_val = rdata; m_result = rdata; end
                else m_result = b;
            end else begin
                exp_done = TIMEOUT + 1; exp_err = 1;
            end
        end else begin
            exp_done = 1; exp_err = 1;
        end
        ext_early = (ext_n >= 1) && wb && (ext_n <= w);
        ext_late  = (ext_n >= 1) && (ext_n <= exp_done) && !ext_early;
        if (ext_early) m_regs[ext_idx] = ext_data;
        if (wb) m_regs[rd] = wb_val;
        if (ext_late) m_regs[ext_idx] = ext_data;

        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_valid = 1'b1;
        reg_wr_en = (ext_n == 0); reg_wr_idx = ext_idx; reg_wr_data = ext_data;
        @(negedge aclk);
        chk("ready_before_accept", 32'(instr_ready), 32'd1);
        @(posedge aclk); #1;
        instr_valid = 1'b0;
        n = 1; done_n = 0; req_cnt = 0; addr_ok = 1;
        while (done_n == 0 && n <= 40) begin
            reg_wr_en = (ext_n == n);
            mem_ack   = is_mem ? (ack_k == n) : 1'($urandom);
            mem_rdata = (is_mem && ack_k == n) ? rdata : 8'($urandom);
            @(negedge aclk);
            if (mem_req) begin
                req_cnt++;
                if (mem_addr !== a || mem_wdata !== b || mem_we !== (op == OP_STORE)) addr_ok = 0;
            end
            if (n == 1 && is_alu) begin
                chk("exec_alu_a", 32'(alu_a), 32'(a));
                chk("exec_alu_b", 32'(alu_b), 32'(b));
                chk("exec_alu_op", 32'(alu_op), 32'(op));
            end
            if (done) done_n = n;
            else begin
                @(posedge aclk); #1;
                n++;
            end
        end
        chk("done_cycle", 32'(done_n), 32'(exp_done));
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_result", 32'(result), 32'(m_result));
        chk("mem_req_cycles", 32'(req_cnt), is_mem ? 32'(exp_done - 1) : 32'd0);
        chk("mem_addr_data_stable", 32'(addr_ok), 32'd1);
        @(posedge aclk); #1;
        reg_wr_en = 1'b0; mem_ack = 1'b0;
        @(negedge aclk);
        chk("ready_after_done", 32'(instr_ready), 32'd1);
        chk("idle_not_busy", 32'(busy), 32'd0);
        check_rf("regfile");
        @(posedge aclk); #1;
    endtask

    typedef struct {
        opcode_t    op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] va, vb;
        logic [7:0] exp_res;
        logic       exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{OP_ADD, 2'd2, 2'd0, 2'd1, 8'hF0, 8'h25, 8'h15, 1'b0};
        tbl[1] = '{OP_AND, 2'd0, 2'd0, 2'd1, 8'h3C, 8'hFF, 8'h3C, 1'b0};
        tbl[2] = '{OP_XOR, 2'd3, 2'd0, 2'd1, 8'h3C, 8'hFF, 8'hC3, 1'b0};
        tbl[3] = '{OP_ADD, 2'd0, 2'd0, 2'd1, 8'hFF, 8'h01, 8'h00, 1'b0};
        tbl[4] = '{OP_XOR, 2'd1, 2'd2, 2'd1, 8'h5A, 8'hA5, 8'hFF, 1'b0};
        tbl[5] = '{OP_ADD, 2'd3, 2'd3, 2'd3, 8'h80, 8'h80, 8'h00, 1'b0};
        tbl[6] = '{opcode_t'(3'd7), 2'd1, 2'd0, 2'd1, 8'h12, 8'h34, 8'h00, 1'b1};
        tbl[7] = '{opcode_t'(3'd5), 2'd2, 2'd0, 2'd1, 8'h56, 8'h78, 8'h00, 1'b1};

        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_result = 8'h00;
        aresetn = 1'b0; instr_valid = 1'b0; instr_op = OP_ADD;
        instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        reg_wr_en = 1'b0; reg_wr_idx = '0; reg_wr_data = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(OP_ADD));
        check_rf("rst_regfile");
        aresetn = 1'b1;
        @(posedge aclk); #1;

        foreach (tbl[i]) begin
            set_reg(tbl[i].rs1, tbl[i].va);
            if (tbl[i].rs2 != tbl[i].rs1) set_reg(tbl[i].rs2, tbl[i].vb);
            run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 0, 8'h00, -1, 2'd0, 8'h00);
            chk("tbl_result", 32'(result), 32'(tbl[i].exp_res));
            chk("tbl_err_latched", 32'(dut.err_q), 32'(tbl[i].exp_err));
        end

        // Back-to-back with instr_valid held high.
        set_reg(2'd0, 8'h3C);
        set_reg(2'd1, 8'hFF);
        instr_op = OP_AND; instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd1; instr_valid = 1'b1;
        @(posedge aclk); #1;
        instr_op = OP_XOR; instr_rd = 2'd3;
        @(negedge aclk);
        chk("b2b_ready_t1", 32'(instr_ready), 32'd0);
        @(negedge aclk);
        chk("b2b_ready_t2", 32'(instr_ready), 32'd0);
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_result1", 32'(result), 32'h3C);
        @(negedge aclk);
        chk("b2b_ready_t3", 32'(instr_ready), 32'd1);
        @(posedge aclk); #1;
        instr_valid = 1'b0;
        @(negedge aclk);
        chk("b2b_exec2_busy", 32'(busy), 32'd1);
        @(negedge aclk);
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_result2", 32'(result), 32'hC3);
        m_regs[0] = 8'h3C; m_regs[3] = 8'hC3; m_result = 8'hC3;
        @(posedge aclk); #1;
        check_rf("b2b_regfile");

        // LOAD with ack on the third MEM cycle.
        set_reg(2'd1, 8'h40);
        run_instr(OP_LOAD, 2'd2, 2'd1, 2'd0, 3, 8'h9A, -1, 2'd0, 8'h00);
        chk("load_reg2", 32'(dut.rf[2]), 32'h9A);
        // STORE timeout, then STORE acked on the last allowed cycle.
        run_instr(OP_STORE, 2'd3, 2'd1, 2'd0, 0, 8'h00, -1, 2'd0, 8'h00);
        chk("store_timeout_err", 32'(dut.err_q), 32'd1);
        run_instr(OP_STORE, 2'd3, 2'd1, 2'd0, TIMEOUT, 8'h00, -1, 2'd0, 8'h00);
        chk("store_ack16_result", 32'(result), 32'(8'h3C));

        // External write colliding with EXEC writeback, and write in the accept cycle.
        set_reg(2'd0, 8'h01);
        set_reg(2'd1, 8'h02);
        run_instr(OP_ADD, 2'd2, 2'd0, 2'd1, 0, 8'h00, 1, 2'd2, 8'h11);
        chk("collision_reg2", 32'(dut.rf[2]), 32'h03);
        run_instr(OP_ADD, 2'd3, 2'd0, 2'd1, 0, 8'h00, 0, 2'd0, 8'h77);
        chk("accept_fwd_result", 32'(result), 32'h79);

        // Reset in the middle of a memory request.
        instr_op = OP_LOAD; instr_rd = 2'd2; instr_rs1 = 2'd1; instr_rs2 = 2'd0; instr_valid = 1'b1;
        mem_ack = 1'b0;
        @(posedge aclk); #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(instr_ready), 32'd1);
        chk("midrst_result", 32'(result), 32'd0);
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_result = 8'h00;
        check_rf("midrst_regfile");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        run_instr(OP_ADD, 2'd0, 2'd1, 2'd2, 0, 8'h00, -1, 2'd0, 8'h00);
        chk("post_reset_add", 32'(result), 32'h00);

        // Randomized instructions against the model.
        for (int t = 0; t < 60; t++) begin
            int r, ak, en;
            opcode_t op;
            r  = int'($urandom_range(0, 9));
            op = (r < 8) ? opcode_t'(r % 5) : opcode_t'(5 + int'($urandom_range(0, 2)));
            ak = (($urandom % 6) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 2));
            en = int'($urandom_range(0, 3)) - 1;
            if (($urandom % 4) == 0) set_reg(2'($urandom), 8'($urandom));
            run_instr(op, 2'($urandom), 2'($urandom), 2'($urandom), ak, 8'($urandom),
                      en, 2'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Single-issue controller that sequences the 8-bit ALU (ADD/AND/XOR) and the LOAD/STORE memory path.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operand/opcode inputs, or issues a memory request with timeout, then writes back and reports completion.
- Sits between the AXI4-Lite slave's command registers and the ALU/memory datapath.

Parameters:
NREGS, 4, number of 8-bit registers in the internal register file (power of 2, ≥2)
IDX_W, $clog2(NREGS), register index width (derived)
TIMEOUT, 16, maximum cycles in MEM before aborting with error (≥2)

Ports:
aclk  in  1  clock, all state on rising edge
aresetn  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  high only in IDLE
instr_op  in  opcode_t  ADD, AND, XOR, LOAD, STORE (params.vh)
instr_rd  in  IDX_W  destination register
instr_rs1  in  IDX_W  operand A / memory address register
instr_rs2  in  IDX_W  operand B / store data register
reg_wr_en  in  1  external register-file write strobe
reg_wr_idx  in  IDX_W  external write index
reg_wr_data  in  8  external write data
alu_a  out  8  ALU operandA
alu_b  out  8  ALU operandB
alu_op  out  opcode_t  ALU opcode
alu_result  in  8  ALU result (combinational)
mem_req  out  1  memory request
mem_we  out  1  1 = STORE, 0 = LOAD
mem_addr  out  8  memory address
mem_wdata  out  8  store data
mem_rdata  in  8  load data, valid with mem_ack
mem_ack  in  1  memory completion
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done: timeout or illegal opcode
result  out  8  valid with done; held until next done

Behaviour:
- Reset (async on aresetn low, from any state, including mid-memory transaction):
  - state=IDLE; all registers and latched fields = 0.
  - instr_ready=1, busy=0, done=0, err=0, result=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - alu_a=0, alu_b=0, alu_op=ADD.
- FSM states: IDLE, EXEC, MEM, DONE.
- IDLE:
  - On instr_valid && instr_ready, latch op/rd/rs1/rs2.
  - ADD/AND/XOR -> EXEC; LOAD/STORE -> MEM with timeout counter cleared.
  - Any other encoding -> DONE with err=1 and no writeback.
- EXEC (exactly 1 cycle):
  - alu_a=reg[rs1], alu_b=reg[rs2], alu_op=latched op.
  - At the closing edge: reg[rd] <= alu_result, result <= alu_result; -> DONE.
- alu_a/alu_b/alu_op hold their last driven values outside EXEC (ALU holds output on memory ops).
- MEM:
  - mem_req=1, mem_we=(op==STORE), mem_addr=reg[rs1], mem_wdata=reg[rs2].
  - Address and data are stable for the whole request.
  - On mem_ack sampled high: LOAD writes reg[rd] <= mem_rdata and result <= mem_rdata; STORE sets result <= reg[rs2]. Then -> DONE, err=0.
  - Counter increments each MEM cycle without ack. When the counter reaches TIMEOUT-1 with no ack: -> DONE, err=1, no writeback, result unchanged.
  - If ack and timeout occur in the same cycle, ack wins.
  - mem_req drops the cycle after ack/timeout.
- DONE: done=1 for one cycle, err valid; -> IDLE.
- Latency (accept edge = T0):
  - ALU op: done in cycle T0+2; instr_ready high again at T0+3.
  - Memory op with ack in k-th MEM cycle: done at T0+k+1.
- Register file:
  - reg_wr_en is honoured in any state.
  - If the FSM writeback targets the same index in the same cycle, the FSM writeback wins.
  - A write in the accept cycle is visible to the EXEC/MEM reads that follow.
  - rd == rs1 or rs2: operands are read before writeback (old values used).
- mem_ack and mem_rdata are ignored outside MEM.
- Arithmetic is modulo 2^8 (ALU truncates; no carry out).

Test Plan:
- reg0=0xF0, reg1=0x25; ADD rd=2 rs1=0 rs2=1 -> alu_a=0xF0, alu_b=0x25 in EXEC; done at T0+2, result=0x15, err=0, reg2=0x15.
- reg0=0x3C, reg1=0xFF; AND rd=0, then XOR rd=3 rs1=0 rs2=1 issued back-to-back (instr_valid held high) -> second accept not before T0+3; results 0x3C then 0xC3.
- reg1=0x40; LOAD rd=2 rs1=1 with mem_ack after 3 cycles, mem_rdata=0x9A -> mem_req=1 and mem_we=0 for 3 cycles at addr 0x40; reg2=0x9A, done with err=0.
- STORE rs1=1 rs2=0 with mem_ack never asserted -> mem_req high exactly 16 cycles, then done with err=1; no register changed. Repeat with ack on cycle 16 -> err=0.
- Reset asserted mid-MEM -> mem_req=0, busy=0, registers=0 immediately; after release, ADD on zeros -> result=0x00.
- reg_wr_en to idx 2 with value 0x11 in the same cycle as EXEC writeback to reg2 -> reg2 holds the ALU result. Illegal opcode -> done with err=1 at T0+1.
